alu_share_ctrl: RTL and testbench

Two-requester controller that shares one combinational 32-bit ALU (ADD/SUB/AND/OR, NZCV flags) between two independent clients. It arbitrates, registers the granted operation onto the ALU inputs, waits a programmable settle time, captures result and flags, and returns them on a tagged valid/ready response channel. It sits between the instruction/issue logic and the shared ALU instance, which stays outside this block.

---
 rtl/alu_share_pkg.sv | 33 +++
 rtl/alu_share_ctrl_if.sv | 49 ++++
 rtl/alu_share_arb.sv | 29 ++
 rtl/alu_share_ctrl.sv | 168 ++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-requester ALU sharing controller:
// op codes, FSM state encoding and response flag bit positions.
package alu_share_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Places the raw ALU flags into their response positions unchanged.
  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request, ALU-side and response signals of alu_share_ctrl.
// The controller takes the slave modport; clients/ALU/consumer take master.
interface alu_share_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              Req0_Valid;
  logic              Req0_Ready;
  logic [DATA_W-1:0] Req0_OperA;
  logic [DATA_W-1:0] Req0_OperB;
  logic [1:0]        Req0_Code;
  logic              Req1_Valid;
  logic              Req1_Ready;
  logic [DATA_W-1:0] Req1_OperA;
  logic [DATA_W-1:0] Req1_OperB;
  logic [1:0]        Req1_Code;
  logic [DATA_W-1:0] Alu_OperA;
  logic [DATA_W-1:0] Alu_OperB;
  logic [1:0]        Alu_Code;
  logic [DATA_W-1:0] Alu_Result;
  logic              Alu_Zero;
  logic              Alu_Negative;
  logic              Alu_Carry;
  logic              Alu_Overflow;
  logic              Rsp_Valid;
  logic              Rsp_Ready;
  logic              Rsp_Id;
  logic [DATA_W-1:0] Rsp_Result;
  logic [3:0]        Rsp_Flags;

  modport slave (
    input  Req0_Valid, Req0_OperA, Req0_OperB, Req0_Code,
    input  Req1_Valid, Req1_OperA, Req1_OperB, Req1_Code,
    input  Alu_Result, Alu_Zero, Alu_Negative, Alu_Carry, Alu_Overflow,
    input  Rsp_Ready,
    output Req0_Ready, Req1_Ready,
    output Alu_OperA, Alu_OperB, Alu_Code,
    output Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Flags
  );

  modport master (
    output Req0_Valid, Req0_OperA, Req0_OperB, Req0_Code,
    output Req1_Valid, Req1_OperA, Req1_OperB, Req1_Code,
    output Alu_Result, Alu_Zero, Alu_Negative, Alu_Carry, Alu_Overflow,
    output Rsp_Ready,
    input  Req0_Ready, Req1_Ready,
    input  Alu_OperA, Alu_OperB, Alu_Code,
    input  Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Flags
  );
endinterface

// File: rtl/alu_share_arb.sv
// Two-way grant logic. ALU_SHARE_RR_EN selects round-robin on contention;
// otherwise requester 0 has fixed priority and no pointer input exists.
module alu_share_arb (
  input  logic [1:0] valid,
`ifdef ALU_SHARE_RR_EN
  input  logic       last_grant,
`endif
  output logic [1:0] grant
);

  // One-hot grant; a lone requester always wins.
  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
`ifdef ALU_SHARE_RR_EN
      if (last_grant) begin
        grant = 2'b01;
      end else begin
        grant = 2'b10;
      end
`else
      grant = 2'b01;
`endif
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two requesters: arbitrate,
// register operands, wait EXEC_CYCLES, capture, respond. Option: ALU_SHARE_RR_EN.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int EXEC_CYCLES = 1
) (
  input logic             clk,
  input logic             rst_n,
  alu_share_ctrl_if.slave bus
);

  localparam int               CNT_W    = $clog2(EXEC_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  if (EXEC_CYCLES < 1) begin : g_bad_exec_cycles
    $error("alu_share_ctrl: EXEC_CYCLES must be at least 1");
  end
  if (DATA_W != 32) begin : g_bad_data_w
    $error("alu_share_ctrl: only DATA_W = 32 is supported");
  end

  state_t            state_r;
  state_t            state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [1:0]        req_valid_s;
  logic [1:0]        grant_s;
  logic [1:0]        ready_s;
  logic              accept_s;
  logic              capture_s;
  logic              release_s;
  logic [DATA_W-1:0] alu_opa_r;
  logic [DATA_W-1:0] alu_opb_r;
  logic [1:0]        alu_code_r;
  logic              id_r;
  logic              rsp_valid_r;
  logic              rsp_id_r;
  logic [DATA_W-1:0] rsp_result_r;
  logic [3:0]        rsp_flags_r;
`ifdef ALU_SHARE_RR_EN
  logic              last_grant_r;
`endif

  assign req_valid_s = {bus.Req1_Valid, bus.Req0_Valid};

  alu_share_arb u_arb (
    .valid      (req_valid_s),
`ifdef ALU_SHARE_RR_EN
    .last_grant (last_grant_r),
`endif
    .grant      (grant_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: if (accept_s)  state_s = ST_EXEC; else state_s = ST_IDLE;
      ST_EXEC: if (capture_s) state_s = ST_RESP; else state_s = ST_EXEC;
      ST_RESP: if (release_s) state_s = ST_IDLE; else state_s = ST_RESP;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM outputs; Ready is held low while reset is asserted so every output reads 0.
  always_comb begin
    ready_s   = 2'b00;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    release_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rst_n) begin
          ready_s = grant_s;
        end else begin
          ready_s = 2'b00;
        end
        accept_s = |ready_s;
      end
      ST_EXEC: capture_s = (cnt_r == CNT_ZERO);
      ST_RESP: release_s = bus.Rsp_Ready;
      default: ready_s = 2'b00;
    endcase
  end

  // Operand registers and settle counter, loaded on the request handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opa_r  <= {DATA_W{1'b0}};
      alu_opb_r  <= {DATA_W{1'b0}};
      alu_code_r <= 2'b00;
      id_r       <= 1'b0;
      cnt_r      <= CNT_ZERO;
    end else if (accept_s) begin
      if (ready_s[1]) begin
        alu_opa_r  <= bus.Req1_OperA;
        alu_opb_r  <= bus.Req1_OperB;
        alu_code_r <= bus.Req1_Code;
      end else begin
        alu_opa_r  <= bus.Req0_OperA;
        alu_opb_r  <= bus.Req0_OperB;
        alu_code_r <= bus.Req0_Code;
      end
      id_r  <= ready_s[1];
      cnt_r <= CNT_LOAD;
    end else if (state_r == ST_EXEC && !capture_s) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Response registers: capture at end of settle, clear valid on consumer handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_result_r <= {DATA_W{1'b0}};
      rsp_flags_r  <= 4'b0000;
    end else if (capture_s) begin
      rsp_valid_r  <= 1'b1;
      rsp_id_r     <= id_r;
      rsp_result_r <= bus.Alu_Result;
      rsp_flags_r  <= pack_flags(bus.Alu_Negative, bus.Alu_Zero,
                                 bus.Alu_Carry, bus.Alu_Overflow);
    end else if (release_s) begin
      rsp_valid_r  <= 1'b0;
    end else begin
      rsp_valid_r  <= rsp_valid_r;
    end
  end

`ifdef ALU_SHARE_RR_EN
  // Last-grant pointer; starts at 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      last_grant_r <= ready_s[1];
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`endif

  assign bus.Req0_Ready = ready_s[0];
  assign bus.Req1_Ready = ready_s[1];
  assign bus.Alu_OperA  = alu_opa_r;
  assign bus.Alu_OperB  = alu_opb_r;
  assign bus.Alu_Code   = alu_code_r;
  assign bus.Rsp_Valid  = rsp_valid_r;
  assign bus.Rsp_Id     = rsp_id_r;
  assign bus.Rsp_Result = rsp_result_r;
  assign bus.Rsp_Flags  = rsp_flags_r;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: vector table, directed corner
// sequences and randomized ops against a behavioural model of ALU + arbitration.
module tb_alu_share_ctrl;
  import alu_share_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_share_ctrl_if #(.DATA_W(32)) if1 ();
  alu_share_ctrl_if #(.DATA_W(32)) if3 ();

  alu_share_ctrl #(.DATA_W(32), .EXEC_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  alu_share_ctrl #(.DATA_W(32), .EXEC_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  int n_checks = 0;
  int n_errors = 0;
  bit last_id;

  // Reference ALU: returns {result, N, Z, C, V}; carry on SUB means borrow.
  function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] code);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0; v = 1'b0;
    case (code)
      ALU_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      ALU_SUB: begin
        r = a - b; c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      ALU_AND: r = a & b;
      default: r = a | b;
    endcase
    return {r, r[31], (r == 32'd0), c, v};
  endfunction

  assign {if1.Alu_Result, if1.Alu_Negative, if1.Alu_Zero, if1.Alu_Carry, if1.Alu_Overflow} =
         ref_alu(if1.Alu_OperA, if1.Alu_OperB, if1.Alu_Code);
  assign {if3.Alu_Result, if3.Alu_Negative, if3.Alu_Zero, if3.Alu_Carry, if3.Alu_Overflow} =
         ref_alu(if3.Alu_OperA, if3.Alu_OperB, if3.Alu_Code);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive1(input bit id, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] c);
    if (id) begin
      if1.Req1_Valid = v; if1.Req1_OperA = a; if1.Req1_OperB = b; if1.Req1_Code = c;
    end else begin
      if1.Req0_Valid = v; if1.Req0_OperA = a; if1.Req0_OperB = b; if1.Req0_Code = c;
    end
  endtask

  task automatic wait_grant1(input bit id, output bit ok);
    ok = 1'b0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if ((id ? if1.Req1_Ready : if1.Req0_Ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Counts negedges after the handshake edge until Rsp_Valid is seen.
  task automatic wait_rsp1(output int lat);
    lat = 0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      lat++;
      if (if1.Rsp_Valid === 1'b1) break;
    end
  endtask

  task automatic op1(input bit id, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] c, output int lat, output bit ok);
    if1.Rsp_Ready = 1'b1;
    drive1(id, 1'b1, a, b, c);
    wait_grant1(id, ok);
    @(posedge clk); #1;
    drive1(id, 1'b0, a, b, c);
    wait_rsp1(lat);
  endtask

  typedef struct {
    bit          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  code;
    logic [31:0] exp_res;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs[8];
  bit   exp_order[4];

  initial begin
    int  lat;
    bit  ok;
    bit  got;
    int  w;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  c0, c1;
    bit  v0, v1;
    int  stall, win;
    logic [35:0] expv;

    vecs[0] = '{1'b0, 32'd5,          32'd7,          ALU_ADD, 32'd12,         4'b0000};
    vecs[1] = '{1'b1, 32'd3,          32'd3,          ALU_SUB, 32'd0,          4'b0100};
    vecs[2] = '{1'b1, 32'd0,          32'd1,          ALU_SUB, 32'hFFFF_FFFF,  4'b1010};
    vecs[3] = '{1'b0, 32'h7FFF_FFFF,  32'd1,          ALU_ADD, 32'h8000_0000,  4'b1001};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF,  32'd1,          ALU_ADD, 32'd0,          4'b0110};
    vecs[5] = '{1'b0, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  ALU_AND, 32'h00F0_00F0,  4'b0000};
    vecs[6] = '{1'b1, 32'h8000_0000,  32'd1,          ALU_OR,  32'h8000_0001,  4'b1000};
    vecs[7] = '{1'b0, 32'h8000_0000,  32'd1,          ALU_SUB, 32'h7FFF_FFFF,  4'b0001};
`ifdef ALU_SHARE_RR_EN
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    rst_n = 1'b0;
    drive1(1'b0, 1'b1, 32'd0, 32'd0, 2'b00);
    drive1(1'b1, 1'b1, 32'd0, 32'd0, 2'b00);
    if1.Rsp_Ready = 1'b1;
    if3.Req0_Valid = 1'b0; if3.Req0_OperA = 32'd0; if3.Req0_OperB = 32'd0; if3.Req0_Code = 2'b00;
    if3.Req1_Valid = 1'b0; if3.Req1_OperA = 32'd0; if3.Req1_OperB = 32'd0; if3.Req1_Code = 2'b00;
    if3.Rsp_Ready = 1'b1;

    // Reset state, with both requests pending to show Ready stays low in reset.
    repeat (2) @(negedge clk);
    check("rst_req0_ready", if1.Req0_Ready, 1'b0);
    check("rst_req1_ready", if1.Req1_Ready, 1'b0);
    check("rst_rsp_valid",  if1.Rsp_Valid, 1'b0);
    check("rst_alu_opa",    if1.Alu_OperA, 32'd0);
    check("rst_rsp_result", if1.Rsp_Result, 32'd0);
    check("rst_rsp_flags",  if1.Rsp_Flags, 4'd0);
    drive1(1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
    drive1(1'b1, 1'b0, 32'd0, 32'd0, 2'b00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention with both requesters held valid.
    drive1(1'b0, 1'b1, 32'd1, 32'd1, ALU_ADD);
    drive1(1'b1, 1'b1, 32'd2, 32'd2, ALU_ADD);
    for (int g = 0; g < 4; g++) begin
      ok = 1'b0;
      for (w = 0; w < 10; w++) begin
        @(negedge clk);
        if (if1.Req0_Ready || if1.Req1_Ready) begin ok = 1'b1; break; end
      end
      check("grant_wait", ok, 1'b1);
      check("grant_onehot", if1.Req0_Ready & if1.Req1_Ready, 1'b0);
      got = if1.Req1_Ready;
      check("grant_order", got, exp_order[g]);
      @(posedge clk); #1;
    end
    drive1(1'b0, 1'b0, 32'd1, 32'd1, ALU_ADD);
    wait_grant1(1'b1, ok);
    check("grant_req1_alone", ok, 1'b1);
    @(posedge clk); #1;
    drive1(1'b1, 1'b0, 32'd2, 32'd2, ALU_ADD);
    repeat (4) @(posedge clk);
    #1;

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      op1(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].code, lat, ok);
      check("vec_grant",   ok, 1'b1);
      check("vec_latency", lat, 2);
      check("vec_result",  if1.Rsp_Result, vecs[i].exp_res);
      check("vec_flags",   if1.Rsp_Flags, vecs[i].exp_flags);
      check("vec_id",      if1.Rsp_Id, vecs[i].id);
      @(posedge clk); #1;
    end

    // Response back-pressure: everything holds and no request is accepted.
    if1.Rsp_Ready = 1'b0;
    drive1(1'b0, 1'b1, 32'h1234_0000, 32'h0000_5678, ALU_OR);
    wait_grant1(1'b0, ok);
    check("stall_grant", ok, 1'b1);
    @(posedge clk); #1;
    drive1(1'b0, 1'b1, 32'd9, 32'd9, ALU_ADD);
    drive1(1'b1, 1'b1, 32'd8, 32'd8, ALU_ADD);
    wait_rsp1(lat);
    check("stall_latency", lat, 2);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid",  if1.Rsp_Valid, 1'b1);
      check("stall_result", if1.Rsp_Result, 32'h1234_5678);
      check("stall_id",     if1.Rsp_Id, 1'b0);
      check("stall_flags",  if1.Rsp_Flags, 4'b0000);
      check("stall_ready",  {if1.Req1_Ready, if1.Req0_Ready}, 2'b00);
      @(negedge clk);
    end
    drive1(1'b0, 1'b0, 32'd9, 32'd9, ALU_ADD);
    drive1(1'b1, 1'b0, 32'd8, 32'd8, ALU_ADD);
    if1.Rsp_Ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_released", if1.Rsp_Valid, 1'b0);

    // Reset while in EXEC drops the op.
    @(posedge clk); #1;
    drive1(1'b0, 1'b1, 32'd10, 32'd20, ALU_ADD);
    wait_grant1(1'b0, ok);
    @(posedge clk); #1;
    drive1(1'b1, 1'b1, 32'd3, 32'd4, ALU_SUB);
    rst_n = 1'b0;
    #1;
    check("midrst_alu_opa",  if1.Alu_OperA, 32'd0);
    check("midrst_alu_opb",  if1.Alu_OperB, 32'd0);
    check("midrst_alu_code", if1.Alu_Code, 2'b00);
    check("midrst_result",   if1.Rsp_Result, 32'd0);
    check("midrst_id",       if1.Rsp_Id, 1'b0);
    check("midrst_valid",    if1.Rsp_Valid, 1'b0);
    check("midrst_ready",    {if1.Req1_Ready, if1.Req0_Ready}, 2'b00);
    drive1(1'b0, 1'b0, 32'd10, 32'd20, ALU_ADD);
    drive1(1'b1, 1'b0, 32'd3, 32'd4, ALU_SUB);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("midrst_no_rsp", if1.Rsp_Valid, 1'b0);
    end
    @(posedge clk); #1;
    drive1(1'b0, 1'b1, 32'd100, 32'd23, ALU_ADD);
    drive1(1'b1, 1'b1, 32'd7, 32'd7, ALU_AND);
    @(negedge clk);
    check("postrst_contention", {if1.Req1_Ready, if1.Req0_Ready}, 2'b01);
    @(posedge clk); #1;
    drive1(1'b0, 1'b0, 32'd100, 32'd23, ALU_ADD);
    drive1(1'b1, 1'b0, 32'd7, 32'd7, ALU_AND);
    wait_rsp1(lat);
    check("postrst_latency", lat, 2);
    check("postrst_result",  if1.Rsp_Result, 32'd123);
    check("postrst_id",      if1.Rsp_Id, 1'b0);
    @(posedge clk); #1;
    last_id = 1'b0;

    // Randomized ops against the model.
    for (int it = 0; it < 40; it++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v1 = 1'b1;
      a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
      a1 = $urandom; b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
      c0 = 2'($urandom_range(0, 3));
      c1 = 2'($urandom_range(0, 3));
      stall = $urandom_range(0, 3);
      if (v0 && v1) begin
`ifdef ALU_SHARE_RR_EN
        win = (last_id == 1'b1) ? 0 : 1;
`else
        win = 0;
`endif
      end else begin
        win = v1 ? 1 : 0;
      end
      expv = (win == 1) ? ref_alu(a1, b1, c1) : ref_alu(a0, b0, c0);
      if1.Rsp_Ready = (stall == 0);
      drive1(1'b0, v0, a0, b0, c0);
      drive1(1'b1, v1, a1, b1, c1);
      @(negedge clk);
      check("rnd_grant", {if1.Req1_Ready, if1.Req0_Ready}, (win == 1) ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      drive1(1'b0, 1'b0, a0, b0, c0);
      drive1(1'b1, 1'b0, a1, b1, c1);
      last_id = (win == 1);
      wait_rsp1(lat);
      check("rnd_latency", lat, 2);
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        check("rnd_hold_valid", if1.Rsp_Valid, 1'b1);
      end
      if1.Rsp_Ready = 1'b1;
      check("rnd_result", if1.Rsp_Result, expv[35:4]);
      check("rnd_flags",  if1.Rsp_Flags, expv[3:0]);
      check("rnd_id",     if1.Rsp_Id, (win == 1));
      @(posedge clk); #1;
    end

    // EXEC_CYCLES = 3 instance: operands held three cycles, response at +4.
    if3.Req1_Valid = 1'b1; if3.Req1_OperA = 32'd50; if3.Req1_OperB = 32'd8; if3.Req1_Code = ALU_SUB;
    @(negedge clk);
    check("ec3_grant", if3.Req1_Ready, 1'b1);
    @(posedge clk); #1;
    if3.Req1_Valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("ec3_alu_opa",  if3.Alu_OperA, 32'd50);
      check("ec3_alu_opb",  if3.Alu_OperB, 32'd8);
      check("ec3_alu_code", if3.Alu_Code, ALU_SUB);
      check("ec3_no_rsp",   if3.Rsp_Valid, 1'b0);
    end
    @(negedge clk);
    check("ec3_rsp_valid", if3.Rsp_Valid, 1'b1);
    check("ec3_result",    if3.Rsp_Result, 32'd42);
    check("ec3_id",        if3.Rsp_Id, 1'b1);
    check("ec3_flags",     if3.Rsp_Flags, 4'b0000);
    @(posedge clk); #1;
    @(negedge clk);
    check("ec3_released",  if3.Rsp_Valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
